// File: rtl/cdb_arbiter.sv
// Purpose: arbitrates the Common Data Bus between result producers (0=LSB, 1=ALU, 2=branch)
//          and broadcasts the winner's ROB tag/value through a registered output.
// Latency: 1 cycle from the transfer edge (src_valid_i & src_ready_o) to cdb_valid_o.
// Backpressure: rdy_i=0 freezes every register and drops all grants; clear_i=1 drops grants
//               and kills the next broadcast without touching data or the round-robin pointer.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   rdy_i          global ready, 0 freezes the block
//   clear_i        synchronous misprediction flush
//   src_valid_i    per-source result pending
//   src_rob_id_i   flattened tags, source i at [i*ROB_W +: ROB_W]
//   src_value_i    flattened results, source i at [i*DATA_W +: DATA_W]
//   src_ready_o    combinational grant, one-hot or zero
//   cdb_valid_o    broadcast valid
//   cdb_rob_id_o   broadcast tag
//   cdb_value_o    broadcast value
//   cdb_src_o      index of the broadcasting source
//
// Build option: define CDB_FIXED_PRIO_EN for strict fixed priority (lowest index wins,
// no round-robin pointer); otherwise round-robin starting after the last winner.

module cdb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int SRC_W   = 2,
    parameter int ROB_W   = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      rdy_i,
    input  logic                      clear_i,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    input  logic [NUM_SRC*ROB_W-1:0]  src_rob_id_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_value_i,
    output logic [NUM_SRC-1:0]        src_ready_o,
    output logic                      cdb_valid_o,
    output logic [ROB_W-1:0]          cdb_rob_id_o,
    output logic [DATA_W-1:0]         cdb_value_o,
    output logic [SRC_W-1:0]          cdb_src_o
);

    logic               cdb_valid_q;
    logic [ROB_W-1:0]   cdb_rob_id_q;
    logic [DATA_W-1:0]  cdb_value_q;
    logic [SRC_W-1:0]   cdb_src_q;

    logic               grant_any;
    logic [SRC_W-1:0]   grant_idx;
    logic [NUM_SRC-1:0] grant;
    logic [ROB_W-1:0]   sel_rob_id;
    logic [DATA_W-1:0]  sel_value;

`ifdef CDB_FIXED_PRIO_EN
    // Lowest index wins; scanning downward lets the lowest valid index overwrite.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid_i[i]) begin
                grant_any = 1'b1;
                grant_idx = SRC_W'(i);
            end
        end
    end
`else
    logic [SRC_W-1:0]     last_grant_q;
    logic [SRC_W-1:0]     last_grant_d;
    logic [2*NUM_SRC-1:0] req_dbl;
    logic [NUM_SRC-1:0]   req_rot;
    logic [SRC_W-1:0]     rot_off;
    logic [SRC_W:0]       win_sum;

    // Rotate the request vector so bit 0 is the source right after the last winner;
    // duplicating the vector makes the shift wrap modulo NUM_SRC.
    always_comb begin
        req_dbl   = {src_valid_i, src_valid_i};
        req_rot   = NUM_SRC'(req_dbl >> ({1'b0, last_grant_q} + 1'b1));
        grant_any = 1'b0;
        rot_off   = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (!grant_any && req_rot[j]) begin
                grant_any = 1'b1;
                rot_off   = SRC_W'(j);
            end
        end
        // Map the rotated offset back to a source index; sum never exceeds 2*NUM_SRC-1.
        win_sum = {1'b0, last_grant_q} + {1'b0, rot_off} + (SRC_W+1)'(1);
        if (win_sum >= (SRC_W+1)'(NUM_SRC)) begin
            win_sum = win_sum - (SRC_W+1)'(NUM_SRC);
        end
        grant_idx = win_sum[SRC_W-1:0];
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (rdy_i && !clear_i && grant_any) begin
            last_grant_d = grant_idx;
        end
    end

    // Reset to the last source so source 0 gets first pick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= SRC_W'(NUM_SRC - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // One-hot grant and winner data select; gated off while frozen or flushing.
    always_comb begin
        grant      = '0;
        sel_rob_id = '0;
        sel_value  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rdy_i && !clear_i && grant_any && (grant_idx == SRC_W'(i))) begin
                grant[i]   = 1'b1;
                sel_rob_id = src_rob_id_i[i*ROB_W +: ROB_W];
                sel_value  = src_value_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= '0;
        end else if (rdy_i) begin
            if (clear_i) begin
                cdb_valid_q <= 1'b0;
            end else if (|grant) begin
                cdb_valid_q  <= 1'b1;
                cdb_rob_id_q <= sel_rob_id;
                cdb_value_q  <= sel_value;
                cdb_src_q    <= grant_idx;
            end else begin
                cdb_valid_q <= 1'b0;
            end
        end
    end

    assign src_ready_o  = grant;
    assign cdb_valid_o  = cdb_valid_q;
    assign cdb_rob_id_o = cdb_rob_id_q;
    assign cdb_value_o  = cdb_value_q;
    assign cdb_src_o    = cdb_src_q;

endmodule
